// File: rtl/mdio_receptor_if.sv
// MDIO receptor bus: serial frame from the management controller and the
// register-side strobes, address, data and serial read path.
interface mdio_receptor_if;
    logic        MDIO_OUT;
    logic        MDIO_OE;
    logic [15:0] RD_DATA;
    logic        MDIO_IN;
    logic        WR_STB;
    logic        MDIO_DONE;
    logic [4:0]  ADDR;
    logic [15:0] WR_DATA;

    modport master (
        output MDIO_OUT, MDIO_OE, RD_DATA,
        input  MDIO_IN, WR_STB, MDIO_DONE, ADDR, WR_DATA
    );

    modport slave (
        input  MDIO_OUT, MDIO_OE, RD_DATA,
        output MDIO_IN, WR_STB, MDIO_DONE, ADDR, WR_DATA
    );
endinterface

// File: rtl/mdio_receptor.sv
// Clause 22 MDIO frame receiver (PHY side): decodes write/read frames on MDC
// and serializes register read data back onto MDIO_IN.
module mdio_receptor (
    input  logic           MDC,
    input  logic           rst,
    mdio_receptor_if.slave bus
);
    typedef enum logic [1:0] {IDLE, HEADER, WRITE, READ} state_t;

    state_t      state, state_n;
    logic [4:0]  cnt, cnt_n;
    logic [31:0] sh, sh_n;
    logic [15:0] rd_sh, rd_sh_n;
    logic        mdio_in_q, mdio_in_n;
    logic        wr_stb_q, wr_stb_n;
    logic        done_q, done_n;
    logic [4:0]  addr_q, addr_n;
    logic [15:0] wr_data_q, wr_data_n;
    logic [31:0] frame_n;

    assign frame_n       = {sh[30:0], bus.MDIO_OUT};
    assign bus.MDIO_IN   = mdio_in_q;
    assign bus.WR_STB    = wr_stb_q;
    assign bus.MDIO_DONE = done_q;
    assign bus.ADDR      = addr_q;
    assign bus.WR_DATA   = wr_data_q;

    always_ff @(posedge MDC or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sh        <= '0;
            rd_sh     <= '0;
            mdio_in_q <= 1'b0;
            wr_stb_q  <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sh        <= sh_n;
            rd_sh     <= rd_sh_n;
            mdio_in_q <= mdio_in_n;
            wr_stb_q  <= wr_stb_n;
            done_q    <= done_n;
            addr_q    <= addr_n;
            wr_data_q <= wr_data_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        rd_sh_n   = rd_sh;
        mdio_in_n = 1'b0;
        wr_stb_n  = 1'b0;
        done_n    = 1'b0;
        addr_n    = addr_q;
        wr_data_n = wr_data_q;

        case (state)
            IDLE: begin
                if (bus.MDIO_OE) begin
                    sh_n    = frame_n;
                    cnt_n   = 5'd1;
                    state_n = HEADER;
                end
            end
            HEADER: begin
                if (!bus.MDIO_OE) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    sh_n = frame_n;
                    if (cnt == 5'd15) begin
                        // frame_n[15:0] now holds bits 31..16: ST, OP, PHYAD, REGAD, TA
                        cnt_n = '0;
                        if (frame_n[15:12] == 4'b0101) begin
                            state_n = WRITE;
                        end else if (frame_n[15:12] == 4'b0110) begin
                            addr_n    = frame_n[6:2];
                            rd_sh_n   = bus.RD_DATA;
                            mdio_in_n = bus.RD_DATA[15];
                            state_n   = READ;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end
            WRITE: begin
                if (!bus.MDIO_OE) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    sh_n = frame_n;
                    if (cnt == 5'd15) begin
                        addr_n    = frame_n[22:18];
                        wr_data_n = frame_n[15:0];
                        wr_stb_n  = 1'b1;
                        done_n    = 1'b1;
                        cnt_n     = '0;
                        state_n   = IDLE;
                    end else begin
                        cnt_n = cnt + 5'd1;
                    end
                end
            end
            READ: begin
                // bit 15 went out on entry; the remaining bits follow MSB first
                if (cnt == 5'd15) begin
                    done_n  = 1'b1;
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    mdio_in_n = rd_sh[14];
                    rd_sh_n   = {rd_sh[14:0], 1'b0};
                    cnt_n     = cnt + 5'd1;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_mdio_receptor.sv
// Self-checking bench for mdio_receptor: table of frames plus hand-written
// abort/reset/back-to-back sequences, checked cycle by cycle from a queue.
module tb_mdio_receptor;
    logic MDC;
    logic rst;

    mdio_receptor_if bus ();

    mdio_receptor dut (
        .MDC (MDC),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        mdio_in;
        logic        wr_stb;
        logic        done;
        logic [4:0]  addr;
        logic [15:0] wr_data;
    } exp_t;

    typedef enum int {K_WRITE, K_READ, K_INVALID} kind_t;

    typedef struct {
        kind_t       kind;
        logic [31:0] frame;
        logic [15:0] rd;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_pulses = 0;

    logic [4:0]  m_addr;
    logic [15:0] m_wr;

    initial begin
        MDC = 1'b0;
        forever #5 MDC = ~MDC;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare_now(input exp_t e);
        check("mdio_in", {31'd0, bus.MDIO_IN}, {31'd0, e.mdio_in});
        check("wr_stb", {31'd0, bus.WR_STB}, {31'd0, e.wr_stb});
        check("mdio_done", {31'd0, bus.MDIO_DONE}, {31'd0, e.done});
        check("addr", {27'd0, bus.ADDR}, {27'd0, e.addr});
        check("wr_data", {16'd0, bus.WR_DATA}, {16'd0, e.wr_data});
        if (bus.MDIO_DONE === 1'b1) done_pulses++;
    endtask

    // Drive one MDC cycle; expectation for outputs after the edge is queued,
    // then popped and compared once the edge has happened.
    task automatic cycle(input logic oe, input logic b, input exp_t e);
        exp_t got;
        @(negedge MDC);
        bus.MDIO_OE  = oe;
        bus.MDIO_OUT = b;
        exp_q.push_back(e);
        @(posedge MDC);
        #1;
        got = exp_q.pop_front();
        compare_now(got);
    endtask

    function automatic exp_t hold();
        exp_t e;
        e.mdio_in = 1'b0;
        e.wr_stb  = 1'b0;
        e.done    = 1'b0;
        e.addr    = m_addr;
        e.wr_data = m_wr;
        return e;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, hold());
    endtask

    function automatic logic [31:0] mk(input logic [1:0] st, input logic [1:0] op,
                                       input logic [4:0] phy, input logic [4:0] ra,
                                       input logic [15:0] d);
        return {st, op, phy, ra, 2'b10, d};
    endfunction

    // Sends the first n bits of f with no strobe expected.
    task automatic send_partial(input logic [31:0] f, input int n);
        for (int i = 31; i > 31 - n; i--) cycle(1'b1, f[i], hold());
    endtask

    task automatic write_frame(input logic [31:0] f);
        exp_t e;
        send_partial(f, 31);
        m_addr = f[22:18];
        m_wr   = f[15:0];
        e = hold();
        e.wr_stb = 1'b1;
        e.done   = 1'b1;
        cycle(1'b1, f[0], e);
    endtask

    task automatic read_frame(input logic [31:0] f, input logic [15:0] rd);
        exp_t e;
        bus.RD_DATA = rd;
        send_partial(f, 15);
        m_addr = f[22:18];
        e = hold();
        e.mdio_in = rd[15];
        cycle(1'b1, f[16], e);
        for (int i = 14; i >= 0; i--) begin
            e = hold();
            e.mdio_in = rd[i];
            cycle(1'b0, 1'b0, e);
        end
        e = hold();
        e.done = 1'b1;
        cycle(1'b0, 1'b0, e);
    endtask

    vec_t vecs[6];

    initial begin
        int dp_before;
        exp_t z;
        bus.MDIO_OE  = 1'b0;
        bus.MDIO_OUT = 1'b0;
        bus.RD_DATA  = 16'h0000;
        m_addr = '0;
        m_wr   = '0;

        // Reset asserted before any MDC edge.
        rst = 1'b1;
        #2;
        z = hold();
        compare_now(z);
        @(negedge MDC);
        rst = 1'b0;
        idle_cycles(10);

        vecs[0] = '{K_WRITE,   mk(2'b01, 2'b01, 5'd1, 5'd3, 16'hABCD), 16'h0000};
        vecs[1] = '{K_READ,    mk(2'b01, 2'b10, 5'd1, 5'd5, 16'h0000), 16'h5A3C};
        // Invalid frames: the data half is also an invalid header, so the
        // receiver restarts on it and drops it too.
        vecs[2] = '{K_INVALID, mk(2'b00, 2'b01, 5'd2, 5'd9, 16'h0000), 16'h0000};
        vecs[3] = '{K_INVALID, mk(2'b01, 2'b11, 5'd3, 5'd12, 16'hFFFF), 16'h0000};
        vecs[4] = '{K_WRITE,   mk(2'b01, 2'b01, 5'd31, 5'd31, 16'h8001), 16'h0000};
        vecs[5] = '{K_READ,    mk(2'b01, 2'b10, 5'd0, 5'd0, 16'h0000), 16'hFFFF};

        for (int v = 0; v < 6; v++) begin
            case (vecs[v].kind)
                K_WRITE:   write_frame(vecs[v].frame);
                K_READ:    read_frame(vecs[v].frame, vecs[v].rd);
                default:   send_partial(vecs[v].frame, 32);
            endcase
            idle_cycles(2);
        end

        // Abort a write after bit 20, then a clean write.
        send_partial(mk(2'b01, 2'b01, 5'd4, 5'd17, 16'hDEAD), 20);
        idle_cycles(3);
        write_frame(mk(2'b01, 2'b01, 5'd1, 5'd7, 16'h1234));
        idle_cycles(1);

        // Async reset mid-frame at bit 10.
        send_partial(mk(2'b01, 2'b01, 5'd4, 5'd17, 16'hBEEF), 10);
        rst = 1'b1;
        m_addr = '0;
        m_wr   = '0;
        #1;
        compare_now(hold());
        @(negedge MDC);
        rst = 1'b0;
        idle_cycles(2);
        write_frame(mk(2'b01, 2'b01, 5'd1, 5'd7, 16'h1234));

        // Back-to-back write then read, no gap.
        dp_before = done_pulses;
        write_frame(mk(2'b01, 2'b01, 5'd6, 5'd21, 16'h0F0F));
        read_frame(mk(2'b01, 2'b10, 5'd6, 5'd22, 16'h0000), 16'hC3A5);
        idle_cycles(2);
        check("b2b_done_count", done_pulses - dp_before, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/mdio_receptor.md
# mdio_receptor

MDIO (IEEE 802.3 Clause 22) management-frame receiver on the PHY side of the link. It deserializes 32-bit frames that the management controller drives on MDIO_OUT/MDIO_OE, clocked by MDC. Write frames present the register address and data on a one-cycle strobe. Read frames present the register address and return RD_DATA serially on MDIO_IN.

## Interface
- No parameters.
- MDC  input  1  clock; all sampling and output updates occur on its rising edge.
- rst  input  1  reset; one clock, asynchronous and active-high.
- MDIO_OUT  input  1  serial frame bit from the controller, MSB first.
- MDIO_OE  input  1  high while the controller drives MDIO_OUT.
- RD_DATA  input  16  register contents to return on a read.
- MDIO_IN  output  1  serial read data toward the controller.
- WR_STB  output  1  one-cycle write strobe.
- MDIO_DONE  output  1  one-cycle end-of-transaction pulse.
- ADDR  output  5  register address (REGAD) of the current or last frame.
- WR_DATA  output  16  data of the last write frame.

## Operation
- Frame layout, bit 31 sent first:
  - ST[31:30] = 01
  - OP[29:28]: 01 = write, 10 = read
  - PHYAD[27:23]
  - REGAD[22:18]
  - TA[17:16]
  - DATA[15:0]
- PHYAD and TA are not checked; every PHYAD is accepted.
- States:
  - IDLE
    - Rising edge with MDIO_OE=1: shift in MDIO_OUT, bit count = 1, go to HEADER.
  - HEADER
    - Shift one bit per edge while MDIO_OE=1.
    - MDIO_OE=0 before 16 bits: abort to IDLE with no outputs.
    - On the 16th bit:
      - ST=01, OP=01: go to WRITE.
      - ST=01, OP=10: ADDR <= REGAD, capture RD_DATA into the read shift register, MDIO_IN <= RD_DATA[15], go to READ.
      - Any other ST/OP: discard the frame, go to IDLE.
  - WRITE
    - Shift 16 more bits while MDIO_OE=1.
    - MDIO_OE=0 before bit 32: abort to IDLE; WR_STB stays low and ADDR/WR_DATA keep their old values.
    - On the edge sampling bit 32: ADDR <= REGAD, WR_DATA <= frame[15:0], WR_STB <= 1, MDIO_DONE <= 1, go to IDLE.
  - READ
    - MDIO_OE is ignored; the controller holds it low.
    - Each of the next 15 edges shifts the next RD_DATA bit onto MDIO_IN, MSB to LSB.
    - The 16th edge after entry sets MDIO_IN <= 0 and MDIO_DONE <= 1, then goes to IDLE.
- WR_STB and MDIO_DONE are registered and high for exactly one MDC cycle.
- MDIO_IN is 0 at all times outside READ.
- ADDR and WR_DATA hold their values between transactions.
- Back-to-back frames are accepted:
  - The strobe edge returns the block to IDLE.
  - The next edge with MDIO_OE=1 starts a new frame.
  - No idle gap is required between frames.
- Preamble is not required. Any MDIO_OE=1 cycle in IDLE is taken as bit 31.

## Timing
- Reset (async assert, takes effect without MDC):
  - State = IDLE, bit count = 0, shift registers = 0.
  - MDIO_IN=0, WR_STB=0, MDIO_DONE=0, ADDR=0, WR_DATA=0.
- Reset released: the first MDC edge with MDIO_OE=1 is bit 31.
- Write latency: WR_STB, MDIO_DONE, ADDR and WR_DATA update on the same edge that samples bit 0, with zero added cycles.
- Read timing:
  - RD_DATA is sampled once, on the edge that samples TA bit 16; it must be stable at that edge.
  - MDIO_IN carries RD_DATA[15-i] during the i-th MDC cycle after that edge (i = 0..15).
  - MDIO_DONE pulses during the cycle after bit 0 is presented.
- Reset asserted mid-frame: the frame is dropped, all outputs return to reset values, and no strobe is issued.

## Test plan
- **Reset:** assert rst with no MDC edges.
  - All outputs are 0 immediately.
  - Deassert and hold MDIO_OE=0 for 10 cycles: outputs stay 0.
- **Write:** send 01 01 00001 00011 10 0xABCD.
  - On the 32nd edge: ADDR=3, WR_DATA=0xABCD, WR_STB=1 and MDIO_DONE=1 for one cycle.
  - MDIO_IN stays 0 throughout.
- **Read:** with RD_DATA=0x5A3C, send 01 10 00001 00101 10, then drop MDIO_OE.
  - ADDR=5.
  - MDIO_IN serial sequence = 0101101000111100 over the next 16 cycles.
  - MDIO_DONE pulses once afterwards; WR_STB stays 0.
- **Invalid frame:** send ST=00 or OP=11 with a full 32 bits.
  - No WR_STB, no MDIO_DONE, MDIO_IN=0.
  - ADDR and WR_DATA keep their prior values.
- **Abort:** drop MDIO_OE after bit 20 of a write, or assert rst at bit 10.
  - No strobe is issued.
  - A following valid write to REGAD 7 with data 0x1234 completes correctly.
- **Back-to-back:** a write then a read with no gap between them.
  - Both transactions complete.
  - MDIO_DONE pulses twice.
